// File: rtl/fir_out_pkg.sv
// Shared types and helpers for the FIR output serializer.
package fir_out_pkg;

  localparam int DEF_OUT_W = 16;
  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  // Serializer frame states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Round-half-up then saturate a 32-bit sample to 16 bits after a right shift
  function automatic logic [15:0] sat_round(input logic signed [31:0] din, input int shift);
    logic signed [32:0] sum;
    logic signed [32:0] q;
    sum = $signed({din[31], din}) + (33'sd1 <<< (shift - 1));
    q   = sum >>> shift;
    if (q > 33'sd32767)
      return SAT_MAX;
    else if (q < -33'sd32768)
      return SAT_MIN;
    else
      return q[15:0];
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy count and registered full/empty flags.
// Handshake: a push is taken only while full is low, a pop only while empty
// is low; both flags come from registered state, so a same-cycle pop never
// reopens a full FIFO and a same-cycle push never makes an empty one poppable.
module sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count_nx;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    count_nx = count;
    if (do_push && !do_pop)
      count_nx = count + 1'b1;
    else if (!do_push && do_pop)
      count_nx = count - 1'b1;
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // Pointers, count and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      full  <= (count_nx == LVL_W'(DEPTH));
      empty <= (count_nx == '0);
    end
  end

endmodule

// File: rtl/fir_sample_serializer.sv
// FIR output stage: round/saturate to 16 bits, buffer, and send as serial PCM
// frames (one fsync bit period, then data MSB first).
module fir_sample_serializer
  import fir_out_pkg::*;
#(
  parameter int IN_W       = 32,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int SHIFT      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_data,
  output logic                          in_ready,
  input  logic                          clr_flags,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sclk,
  output logic                          fsync,
  output logic                          sdata
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CW    = $clog2(CLK_DIV);
  localparam int BW    = $clog2(OUT_W);

  localparam logic signed [IN_W:0] RND   = (IN_W + 1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] Q_MAX = (IN_W + 1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] Q_MIN = (IN_W + 1)'(-(2 ** (OUT_W - 1)));

  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] q;
  logic [OUT_W-1:0]     conv;

  logic [OUT_W-1:0]     pop_data;
  logic                 full;
  logic                 empty;
  logic                 pop_req;

  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nx;
  logic                 bit_tick;

  state_t               state;
  logic [OUT_W-1:0]     shreg;
  logic [BW-1:0]        bit_cnt;

  // Widen by one bit so adding the rounding constant cannot wrap
  assign sum = $signed({in_data[IN_W-1], in_data}) + RND;
  assign q   = sum >>> SHIFT;

  // Clamp the shifted value to the signed output range
  always_comb begin
    conv = q[OUT_W-1:0];
    if (q > Q_MAX)
      conv = {1'b0, {(OUT_W - 1){1'b1}}};
    else if (q < Q_MIN)
      conv = {1'b1, {(OUT_W - 1){1'b0}}};
  end

  sample_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (conv),
    .pop       (pop_req),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_level)
  );

  assign in_ready = !full;

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (in_valid && full)
      overflow <= 1'b1;
    else if (clr_flags)
      overflow <= 1'b0;
  end

  assign bit_tick = (cnt == CW'(CLK_DIV - 1));
  assign cnt_nx   = bit_tick ? '0 : cnt + 1'b1;

  // Free-running bit timer; sclk tracks the upper half of the period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      sclk <= (cnt_nx >= CW'(CLK_DIV / 2));
    end
  end

  // Fetch a new frame from idle, or right after the LSB period of a frame
  assign pop_req = bit_tick && !empty &&
                   ((state == ST_IDLE) || ((state == ST_SHIFT) && (bit_cnt == '0)));

  // Frame sequencer: all outputs change on bit_tick only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      fsync   <= 1'b0;
      sdata   <= 1'b0;
    end else if (bit_tick) begin
      case (state)
        ST_IDLE: begin
          sdata <= 1'b0;
          if (pop_req) begin
            shreg <= pop_data;
            fsync <= 1'b1;
            state <= ST_SYNC;
          end else begin
            fsync <= 1'b0;
          end
        end
        ST_SYNC: begin
          fsync   <= 1'b0;
          sdata   <= shreg[OUT_W-1];
          bit_cnt <= BW'(OUT_W - 1);
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_cnt == '0) begin
            sdata <= 1'b0;
            if (pop_req) begin
              shreg <= pop_data;
              fsync <= 1'b1;
              state <= ST_SYNC;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            shreg   <= shreg << 1;
            sdata   <= shreg[OUT_W-2];
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          fsync <= 1'b0;
          sdata <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_serializer.sv
// Bench for fir_sample_serializer: scoreboarded serial frames plus directed
// timing, overflow and reset checks.
module tb_fir_sample_serializer;

  localparam int IN_W       = 32;
  localparam int OUT_W      = 16;
  localparam int SHIFT      = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int CLK_DIV    = 4;
  localparam int FRAME      = (OUT_W + 1) * CLK_DIV;

  logic                        clk;
  logic                        rst;
  logic                        in_valid;
  logic [IN_W-1:0]             in_data;
  logic                        in_ready;
  logic                        clr_flags;
  logic                        overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        sclk;
  logic                        fsync;
  logic                        sdata;

  int n_vec;
  int n_err;
  int cyc_rel;
  int cyc_abs;
  int frames;
  int f0;

  logic [OUT_W-1:0] exp_q[$];
  int               start_q[$];

  logic             sclk_q;
  logic             mon_busy;
  int               mon_bits;
  logic [OUT_W-1:0] mon_word;
  logic [OUT_W-1:0] mon_next;

  logic [IN_W-1:0]  sat_in  [4];
  logic [OUT_W-1:0] sat_exp [4];

  fir_sample_serializer #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .SHIFT      (SHIFT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .clr_flags  (clr_flags),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .sclk       (sclk),
    .fsync      (fsync),
    .sdata      (sdata)
  );

  // clock / reset-relative cycle counters
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc_rel <= 0;
    else     cyc_rel <= cyc_rel + 1;
  end

  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference for the 32->16 reduction
  function automatic logic [OUT_W-1:0] model_q(input logic [IN_W-1:0] d);
    longint v;
    longint q;
    v = longint'($signed(d));
    q = (v + 64'sd32768) >>> SHIFT;
    if (q > 64'sd32767)  return 16'h7FFF;
    if (q < -64'sd32768) return 16'h8000;
    return q[OUT_W-1:0];
  endfunction

  // Serial monitor: decode frames at sclk rising edges, compare to scoreboard
  always @(negedge clk) begin
    if (rst) begin
      sclk_q   <= 1'b0;
      mon_busy <= 1'b0;
      mon_bits <= 0;
      mon_word <= '0;
    end else begin
      sclk_q <= sclk;
      if (sclk && !sclk_q) begin
        if (!mon_busy) begin
          if (fsync) begin
            mon_busy <= 1'b1;
            mon_bits <= 0;
            mon_word <= '0;
            start_q.push_back(cyc_abs);
          end else begin
            check("idle_sdata", 32'(sdata), 32'd0);
          end
        end else begin
          check("fsync_width", 32'(fsync), 32'd0);
          mon_next = {mon_word[OUT_W-2:0], sdata};
          mon_word <= mon_next;
          mon_bits <= mon_bits + 1;
          if (mon_bits == OUT_W - 1) begin
            mon_busy <= 1'b0;
            frames   <= frames + 1;
            if (exp_q.size() == 0)
              check("unexpected_frame", 32'(mon_next), 32'hDEAD_BEEF);
            else
              check("frame", 32'(mon_next), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // Wait for the negedge following reset-relative edge k
  task automatic goto(input int k);
    int guard;
    guard = 0;
    while (cyc_rel != k && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc_rel != k) check("goto_timeout", 32'(cyc_rel), 32'(k));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    clr_flags = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    start_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int guard;
    guard = 0;
    while (frames < n && guard < 20 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (frames < n) check("frame_timeout", 32'(frames), 32'(n));
  endtask

  // Push ten random samples on edges 1..10; the last one is expected to drop
  task automatic burst10();
    logic [IN_W-1:0] d;
    for (int i = 0; i < 10; i++) begin
      goto(i);
      d        = $urandom();
      in_valid = 1'b1;
      in_data  = d;
      if (i < 9) exp_q.push_back(model_q(d));
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    clr_flags = 1'b0;
    sat_in[0] = 32'h7FFF_9000;  sat_exp[0] = 16'h7FFF;
    sat_in[1] = 32'h8000_0000;  sat_exp[1] = 16'h8000;
    sat_in[2] = 32'hFFFF_7FFF;  sat_exp[2] = 16'hFFFF;
    sat_in[3] = 32'h0000_7FFF;  sat_exp[3] = 16'h0000;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_level",    32'(fifo_level), 32'd0);
    check("rst_sclk",     32'(sclk), 32'd0);
    check("rst_fsync",    32'(fsync), 32'd0);
    check("rst_sdata",    32'(sdata), 32'd0);

    // single frame with exact bit timing
    do_reset();
    f0 = frames;
    goto(0);
    in_valid = 1'b1;
    in_data  = 32'h1234_8000;
    exp_q.push_back(16'h1235);
    goto(1);
    in_valid = 1'b0;
    check("one_level", 32'(fifo_level), 32'd1);
    goto(3);
    check("pre_sync_fsync", 32'(fsync), 32'd0);
    goto(4);
    check("sync_fsync", 32'(fsync), 32'd1);
    check("sync_sdata", 32'(sdata), 32'd0);
    check("sync_level", 32'(fifo_level), 32'd0);
    goto(8);
    check("msb_fsync", 32'(fsync), 32'd0);
    goto(20);
    check("bit12", 32'(sdata), 32'd1);
    goto(71);
    check("lsb", 32'(sdata), 32'd1);
    goto(72);
    check("end_fsync", 32'(fsync), 32'd0);
    check("end_sdata", 32'(sdata), 32'd0);
    wait_frames(f0 + 1);

    // rounding and saturation corners
    do_reset();
    f0 = frames;
    for (int i = 0; i < 4; i++) begin
      goto(i);
      in_valid = 1'b1;
      in_data  = sat_in[i];
      exp_q.push_back(sat_exp[i]);
    end
    goto(4);
    in_valid = 1'b0;
    wait_frames(f0 + 4);

    // overflow burst, clear-vs-drop priority, back-to-back spacing
    do_reset();
    f0 = frames;
    burst10();
    goto(10);
    check("burst_level", 32'(fifo_level), 32'd8);
    check("burst_ready", 32'(in_ready), 32'd0);
    check("burst_ovf",   32'(overflow), 32'd1);
    in_valid  = 1'b1;
    in_data   = $urandom();
    clr_flags = 1'b1;
    goto(11);
    check("clr_vs_drop", 32'(overflow), 32'd1);
    in_valid = 1'b0;
    goto(12);
    check("clr_alone", 32'(overflow), 32'd0);
    clr_flags = 1'b0;
    wait_frames(f0 + 9);
    check("b2b_count", 32'(start_q.size()), 32'd9);
    for (int i = 1; i < start_q.size(); i++)
      check("b2b_gap", 32'(start_q[i] - start_q[i-1]), 32'(FRAME));

    // reset in the middle of a frame
    do_reset();
    burst10();
    goto(10);
    in_valid = 1'b0;
    begin
      int guard;
      guard = 0;
      while (!(mon_busy && mon_bits == 5) && guard < 4 * FRAME) begin
        @(posedge clk);
        guard++;
      end
      check("reach_bit5", 32'(mon_bits), 32'd5);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_sclk",  32'(sclk), 32'd0);
    check("abort_fsync", 32'(fsync), 32'd0);
    check("abort_sdata", 32'(sdata), 32'd0);
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_ovf",   32'(overflow), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0  = frames;
    repeat (300) @(negedge clk);
    check("no_frame_after_rst", 32'(frames), 32'(f0));
    check("idle_level", 32'(fifo_level), 32'd0);

    // push landing on the LSB-end tick: one idle bit period before the next frame
    do_reset();
    f0 = frames;
    goto(0);
    in_valid = 1'b1;
    in_data  = 32'h0102_0000;
    exp_q.push_back(16'h0102);
    goto(1);
    in_valid = 1'b0;
    goto(71);
    in_valid = 1'b1;
    in_data  = 32'hABCD_7FFF;
    exp_q.push_back(16'hABCD);
    goto(72);
    in_valid = 1'b0;
    check("gap_idle_fsync", 32'(fsync), 32'd0);
    check("gap_level", 32'(fifo_level), 32'd1);
    goto(76);
    check("gap_sync_fsync", 32'(fsync), 32'd1);
    check("gap_pop_level", 32'(fifo_level), 32'd0);
    wait_frames(f0 + 2);
    if (start_q.size() >= 2)
      check("gap_spacing", 32'(start_q[1] - start_q[0]), 32'(FRAME + CLK_DIV));
    else
      check("gap_frames", 32'(start_q.size()), 32'd2);

    check("leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_sample_serializer.md
Name: fir_sample_serializer

Overview:
Output stage that consumes the FIR's 32-bit signed result stream and sends it to an external DAC. Each accepted sample is reduced to 16 bits with round-half-up and saturation, then buffered in a small FIFO. The buffered samples are transmitted as a serial PCM frame: a one-bit-period frame-sync, followed by the data MSB first. The block decouples the FIR sample rate from the serial bit clock.

Parameters:
IN_W, 32, input sample width (signed)
OUT_W, 16, serial output sample width (signed)
SHIFT, 16, right-shift applied before rounding and saturation
FIFO_DEPTH, 8, sample buffer entries (power of 2)
CLK_DIV, 4, clk cycles per serial bit period (even, >=2)

Ports:
clk  in  1  system clock
rst  in  1  reset: asynchronous, active-high
in_valid  in  1  in_data holds a sample this cycle
in_data  in  IN_W  signed FIR output sample
in_ready  out  1  FIFO not full
clr_flags  in  1  clears overflow
overflow  out  1  sticky: a sample was dropped
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries
sclk  out  1  serial bit clock
fsync  out  1  frame sync, high for one bit period before the MSB
sdata  out  1  serial data, MSB first

Behaviour:
- Reset values: in_ready=1, overflow=0, fifo_level=0, sclk=0, fsync=0, sdata=0. The FSM is in IDLE and the bit counter is 0.
- Conversion is combinational on the write path:
  - sum = in_data + 2^(SHIFT-1), computed at IN_W+1 bits.
  - q = sum >>> SHIFT (arithmetic shift).
  - If q > 32767, write 0x7FFF. If q < -32768, write 0x8000. Otherwise write q[OUT_W-1:0].
- Push:
  - in_valid && in_ready writes at the clock edge; fifo_level increments on the same edge.
  - in_ready = !full, derived from registered state.
  - A simultaneous pop does not reopen a full FIFO in the same cycle.
  - in_valid && !in_ready drops the sample and sets overflow at that edge.
- overflow clears on clr_flags. If a drop and clr_flags occur in the same cycle, the set wins.
- Bit timer:
  - Free-running counter 0..CLK_DIV-1.
  - sclk = (counter >= CLK_DIV/2), registered.
  - bit_tick occurs when counter == CLK_DIV-1. sdata and fsync change only on bit_tick, so they are stable at the sclk rising edge.
- FSM states IDLE, SYNC, SHIFT, with transitions on bit_tick only:
  - IDLE: if FIFO is non-empty, pop into the shift register, drive fsync=1 and sdata=0, go to SYNC. Otherwise keep fsync=0, sdata=0.
  - SYNC (one bit period): drive fsync=0 and sdata=shreg[OUT_W-1], bit_cnt=OUT_W-1, go to SHIFT.
  - SHIFT: on each bit_tick, shift left and decrement bit_cnt. After the LSB's bit period, if the FIFO is non-empty, pop and go to SYNC with fsync=1 (back-to-back frames). Otherwise go to IDLE with sdata=0.
- Frame length is exactly OUT_W+1 bit periods, i.e. (OUT_W+1)*CLK_DIV clk cycles.
- A pop and a push in the same cycle are legal. A pop only occurs when the FIFO is non-empty per registered state, so a sample pushed into an empty FIFO is popped on a later bit_tick.
- An empty FIFO is not an error: the line stays idle at 0.
- rst asserted mid-frame aborts immediately. All outputs return to reset values and the FIFO is flushed. No partial frame resumes after release.

Decomposition:
- Package fir_out_pkg:
  - OUT_W default, SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000
  - state enum (IDLE, SYNC, SHIFT)
  - function sat_round(in, shift) for reuse by the bench model
- Sub-module sample_fifo: synchronous FIFO with count output and registered full/empty.
- The top level holds the converter, bit timer, FSM and shift register.

Test Plan:
- Single push in_data=32'h1234_8000 -> FIFO value 0x1235. Serial output: fsync high for 1 bit period, then sdata 0001_0010_0011_0101. The frame lasts 68 clk cycles (CLK_DIV=4). The FSM then returns to IDLE with sdata=0.
- Saturation and rounding: 32'h7FFF_9000 -> 0x7FFF; 32'h8000_0000 -> 0x8000; 32'hFFFF_7FFF -> 0xFFFF; 32'h0000_7FFF -> 0x0000.
- Push 10 samples on consecutive cycles right after reset release -> exactly one pop in that window, fifo_level reaches 8, in_ready=0, exactly one sample dropped, overflow=1. The 9 retained samples are transmitted in order, back-to-back, 68 cycles apart.
- Assert clr_flags in the same cycle as a drop -> overflow stays 1. Assert clr_flags alone on the next cycle -> overflow=0.
- Assert rst during the SHIFT state at data bit 5 -> sclk, fsync, sdata, fifo_level and overflow are all 0 immediately. After release, no frame appears until a new push.
- Push a sample at the moment the LSB of the previous frame ends with the FIFO otherwise empty -> the FSM passes through IDLE, and the new frame starts on a later bit_tick with a full SYNC period.
